// File: rtl/risc8_uart_pkg.sv
// Shared constants and the state encoding used by both directions of the risc8 8N1 UART.
// Pure declarations, no logic.
package risc8_uart_pkg;
  localparam int   DATA_BITS = 8;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/risc8_uart_baud_timer.sv
// Down-counting bit timer: load N, tick is high in the cycle the count reaches zero (N+1 cycles after load).
// Holds at zero until reloaded; the owning FSM decides when a tick is meaningful.
module risc8_uart_baud_timer
  import risc8_uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       tick
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign tick = (cnt == 8'd0);

endmodule

// File: rtl/risc8_uart.sv
// Byte-wide 8N1 UART: strobe-fed transmitter with a ready flag, receiver with strobe/frame-error pulses.
// Start bit appears the cycle after tx_strobe; strobes while busy are dropped, nothing is queued.
module risc8_uart
  import risc8_uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] baud_div,
  input  logic       tx_strobe,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_out,
  input  logic       rx_in,
  output logic       rx_strobe,
  output logic [7:0] rx_data,
  output logic       rx_frame_err
);

  // ---------------- transmitter ----------------
  uart_state_t tx_state, tx_state_nx;
  logic [7:0]  tx_div, tx_shift, tx_load_val;
  logic [3:0]  tx_idx;
  logic        tx_load, tx_tick;

  risc8_uart_baud_timer u_tx_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tx_load),
    .load_val (tx_load_val),
    .tick     (tx_tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= IDLE;
      tx_div   <= 8'd0;
      tx_shift <= 8'd0;
      tx_idx   <= 4'd0;
    end else begin
      tx_state <= tx_state_nx;
      if (tx_state == IDLE && tx_strobe) begin
        tx_div   <= baud_div;
        tx_shift <= tx_data;
        tx_idx   <= 4'd0;
      end else if (tx_state == DATA && tx_tick) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_idx   <= tx_idx + 4'd1;
      end
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_load     = 1'b0;
    tx_load_val = tx_div;
    tx_ready    = 1'b0;
    tx_out      = LINE_IDLE;
    case (tx_state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_strobe) begin
          tx_state_nx = START;
          tx_load     = 1'b1;
          tx_load_val = baud_div;
        end
      end
      START: begin
        tx_out = 1'b0;
        if (tx_tick) begin
          tx_state_nx = DATA;
          tx_load     = 1'b1;
        end
      end
      DATA: begin
        tx_out = tx_shift[0];
        if (tx_tick) begin
          tx_load = 1'b1;
          if (tx_idx == 4'(DATA_BITS - 1)) tx_state_nx = STOP;
        end
      end
      STOP: begin
        tx_out = STOP_BIT;
        if (tx_tick) tx_state_nx = IDLE;
      end
      default: tx_state_nx = IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  uart_state_t rx_state, rx_state_nx;
  logic [7:0]  rx_div, rx_shift, rx_load_val, rx_half_m1;
  logic [3:0]  rx_idx;
  logic        rx_load, rx_tick;
  logic        rx_s1, rx_s2, rx_prev, rx_fall;

  risc8_uart_baud_timer u_rx_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (rx_load),
    .load_val (rx_load_val),
    .tick     (rx_tick)
  );

  assign rx_fall    = rx_prev & ~rx_s2;
  // ((baud_div+1)>>1)-1 without a 9-bit intermediate; only used when baud_div != 0
  assign rx_half_m1 = (baud_div - 8'd1) >> 1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1        <= LINE_IDLE;
      rx_s2        <= LINE_IDLE;
      rx_prev      <= LINE_IDLE;
      rx_state     <= IDLE;
      rx_div       <= 8'd0;
      rx_shift     <= 8'd0;
      rx_idx       <= 4'd0;
      rx_data      <= 8'd0;
      rx_strobe    <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_s1        <= rx_in;
      rx_s2        <= rx_s1;
      rx_prev      <= rx_s2;
      rx_state     <= rx_state_nx;
      rx_strobe    <= 1'b0;
      rx_frame_err <= 1'b0;
      if (rx_state == IDLE && rx_fall) begin
        rx_div <= baud_div;
        rx_idx <= 4'd0;
      end
      if (rx_state == DATA && rx_tick) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_idx   <= rx_idx + 4'd1;
      end
      if (rx_state == STOP && rx_tick) begin
        if (rx_s2 == STOP_BIT) begin
          rx_data   <= rx_shift;
          rx_strobe <= 1'b1;
        end else begin
          rx_frame_err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_load     = 1'b0;
    rx_load_val = rx_div;
    case (rx_state)
      IDLE: begin
        if (rx_fall) begin
          rx_load = 1'b1;
          // T=1 has no half-bit wait: the edge cycle itself is the start-bit sample
          if (baud_div == 8'd0) begin
            rx_state_nx = DATA;
            rx_load_val = 8'd0;
          end else begin
            rx_state_nx = START;
            rx_load_val = rx_half_m1;
          end
        end
      end
      START: begin
        if (rx_tick) begin
          if (rx_s2) begin
            rx_state_nx = IDLE;
          end else begin
            rx_state_nx = DATA;
            rx_load     = 1'b1;
          end
        end
      end
      DATA: begin
        if (rx_tick) begin
          rx_load = 1'b1;
          if (rx_idx == 4'(DATA_BITS - 1)) rx_state_nx = STOP;
        end
      end
      STOP: begin
        if (rx_tick) rx_state_nx = IDLE;
      end
      default: rx_state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_risc8_uart.sv
// Bench for risc8_uart: frame-level TX model plus an RX expected-event scoreboard, checked every cycle.
module tb_risc8_uart;

  logic       clk;
  logic       reset;
  logic [7:0] baud_div;
  logic       tx_strobe;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_out;
  logic       rx_in;
  logic       rx_strobe;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       loop_en;
  logic       rx_drv;

  assign rx_in = loop_en ? tx_out : rx_drv;

  risc8_uart dut (
    .clk          (clk),
    .reset        (reset),
    .baud_div     (baud_div),
    .tx_strobe    (tx_strobe),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .tx_out       (tx_out),
    .rx_in        (rx_in),
    .rx_strobe    (rx_strobe),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // TX model: a frame is a 10-bit line image, each bit held T cycles
  logic       m_busy = 1'b0;
  logic [9:0] m_frame = 10'h3FF;
  int         m_pos = 0;
  int         m_T = 1;

  // RX scoreboard: {is_error, data}
  logic [8:0] ev_q[$];
  logic [7:0] exp_rx_data = 8'h00;
  int         n_strobe = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout/unexpected, required completion (t=%0t)", name, $time);
  endtask

  task automatic compare();
    logic [8:0] e;
    logic [3:0] bi;
    bi = 4'(m_pos / m_T);
    chk("tx_ready", 16'(tx_ready), 16'(!m_busy));
    chk("tx_out", 16'(tx_out), m_busy ? 16'(m_frame[bi]) : 16'd1);
    chk("rx_exclusive", 16'(rx_strobe & rx_frame_err), 16'd0);
    if (rx_strobe || rx_frame_err) begin
      if (rx_strobe) n_strobe++;
      else n_err++;
      if (ev_q.size() == 0) begin
        flag_fail("rx_unexpected_event");
      end else begin
        e = ev_q.pop_front();
        chk("rx_kind", 16'(rx_frame_err), 16'(e[8]));
        if (!e[8]) exp_rx_data = e[7:0];
      end
    end
    chk("rx_data", 16'(rx_data), 16'(exp_rx_data));
  endtask

  // one clock: model follows the inputs sampled at the edge, outputs compared at the falling edge
  task automatic step();
    @(posedge clk);
    if (!reset) begin
      m_busy      = 1'b0;
      exp_rx_data = 8'h00;
    end else if (!m_busy) begin
      if (tx_strobe) begin
        m_busy  = 1'b1;
        m_T     = int'(baud_div) + 1;
        m_frame = {1'b1, tx_data, 1'b0};
        m_pos   = 0;
      end
    end else begin
      m_pos++;
      if (m_pos == 10 * m_T) m_busy = 1'b0;
      else if (loop_en && m_pos == 9 * m_T) ev_q.push_back({1'b0, m_frame[8:1]});
    end
    @(negedge clk);
    compare();
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] div);
    int n;
    n = 0;
    while (m_busy && n < 3000) begin
      step();
      n++;
    end
    if (m_busy) flag_fail("send_wait");
    tx_data   = d;
    baud_div  = div;
    tx_strobe = 1'b1;
    step();
    tx_strobe = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((ev_q.size() != 0 || m_busy) && n < 3000) begin
      step();
      n++;
    end
    if (ev_q.size() != 0 || m_busy) flag_fail(name);
    repeat (4) step();
  endtask

  // observe one frame from its first start-bit cycle; optionally strobe 0xFF at cycle inj
  task automatic watch(input int T, input int inj, output logic [9:0] pat,
                       output int low, output int bad);
    logic prev;
    pat  = 10'h0;
    low  = 0;
    bad  = 0;
    prev = tx_out;
    for (int i = 0; i < 10 * T; i++) begin
      if (!tx_ready) low++;
      if (tx_out !== prev && (i % T) != 0) bad++;
      prev = tx_out;
      if (i % T == T / 2) pat = {tx_out, pat[9:1]};
      tx_strobe = (i == inj);
      if (i == inj) tx_data = 8'hFF;
      step();
    end
    tx_strobe = 1'b0;
  endtask

  task automatic drive_frame(input logic [9:0] frame, input int T);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < T; c++) begin
        rx_drv = frame[b];
        step();
      end
    end
  endtask

  initial begin
    logic [9:0] pat;
    int low, bad, s0, e0;

    reset     = 1'b0;
    tx_strobe = 1'b1;
    tx_data   = 8'hA5;
    baud_div  = 8'd5;
    loop_en   = 1'b1;
    rx_drv    = 1'b1;

    // reset held with a strobe pending
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_tx_out", 16'(tx_out), 16'd1);
      chk("rst_tx_ready", 16'(tx_ready), 16'd1);
      chk("rst_rx_strobe", 16'(rx_strobe), 16'd0);
    end
    chk("rst_rx_data", 16'(rx_data), 16'h00);
    reset     = 1'b1;
    tx_strobe = 1'b0;
    repeat (3) step();
    chk("rst_no_frame", 16'(tx_ready), 16'd1);

    // 0x55 at T=6
    send(8'h55, 8'd5);
    watch(6, -1, pat, low, bad);
    chk("tx55_wave", 16'(pat), 16'h2AA);
    chk("tx55_ready_low", 16'(low), 16'd60);
    chk("tx55_edges", 16'(bad), 16'd0);
    chk("tx55_ready_after", 16'(tx_ready), 16'd1);
    drain("tx55_rx_drain");

    // 0xA3 with a dropped strobe at cycle 20
    send(8'hA3, 8'd5);
    watch(6, 20, pat, low, bad);
    chk("busy_wave", 16'(pat), 16'h346);
    chk("busy_ready_low", 16'(low), 16'd60);
    repeat (3) step();
    chk("busy_not_queued", 16'(tx_ready), 16'd1);
    drain("busy_rx_drain");

    // back-to-back loopback at T=4
    s0 = n_strobe;
    e0 = n_err;
    send(8'h00, 8'd3);
    send(8'hFF, 8'd3);
    send(8'h96, 8'd3);
    drain("loop_drain");
    chk("loop_count", 16'(n_strobe - s0), 16'd3);
    chk("loop_last", 16'(rx_data), 16'h96);
    chk("loop_no_err", 16'(n_err - e0), 16'd0);

    // T=1 boundary
    send(8'h5A, 8'd0);
    drain("baud0_drain");
    chk("baud0_data", 16'(rx_data), 16'h5A);

    // framing error for 0x3C, then the line stays low a while
    loop_en  = 1'b0;
    baud_div = 8'd3;
    s0 = n_strobe;
    e0 = n_err;
    ev_q.push_back({1'b1, 8'h00});
    drive_frame({1'b0, 8'h3C, 1'b0}, 4);
    rx_drv = 1'b0;
    repeat (12) step();
    rx_drv = 1'b1;
    drain("ferr_drain");
    repeat (16) step();
    chk("ferr_count", 16'(n_err - e0), 16'd1);
    chk("ferr_no_strobe", 16'(n_strobe - s0), 16'd0);
    chk("ferr_data_held", 16'(rx_data), 16'h5A);

    // one-cycle glitch at T=8
    baud_div = 8'd7;
    s0 = n_strobe + n_err;
    rx_drv = 1'b0;
    step();
    rx_drv = 1'b1;
    repeat (30) step();
    chk("glitch_silent", 16'(n_strobe + n_err - s0), 16'd0);

    // reset during TX/RX data bit 4, then a clean frame
    loop_en = 1'b1;
    s0 = n_strobe;
    send(8'hE7, 8'd3);
    repeat (21) step();
    reset = 1'b0;
    step();
    chk("rstmid_tx_out", 16'(tx_out), 16'd1);
    chk("rstmid_tx_ready", 16'(tx_ready), 16'd1);
    chk("rstmid_rx_data", 16'(rx_data), 16'h00);
    reset = 1'b1;
    repeat (30) step();
    chk("rstmid_no_strobe", 16'(n_strobe - s0), 16'd0);
    send(8'h81, 8'd3);
    drain("rstmid_drain");
    chk("rstmid_next_data", 16'(rx_data), 16'h81);
    chk("final_queue_empty", 16'(ev_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
